// File: rtl/cb_dct_8x8.sv
// Cb-channel 8x8 forward DCT: serial pixel load, row pass then column pass,
// one coefficient per cycle, whole block published at once from a shadow buffer.
module cb_dct_8x8 (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [7:0]            data_in,
  output logic [1:8][1:8][10:0] Z_final,
  output logic                  output_enable
);

  typedef enum logic {LOAD, COMPUTE} state_t;

  state_t state_q, state_d;
  logic [5:0] smp_q, smp_d;
  logic [7:0] cnt_q, cnt_d;

  logic load_en, p1_en, p2_en, xfer;

  logic signed [8:0]  x_q [64];
  logic signed [31:0] t_q [64];
  logic        [10:0] s_q [64];

  logic signed [31:0] acc1;
  logic signed [47:0] acc2;
  logic signed [23:0] rnd;
  logic        [10:0] sat;

  // 2048*cos(m*pi/16) folded onto the first quadrant; row 0 is 4096/(2*sqrt2)
  function automatic logic signed [12:0] coef(
    input logic [2:0] u,
    input logic [2:0] n
  );
    logic [4:0] m;
    logic [4:0] a;
    logic [4:0] b;
    logic signed [12:0] mag;
    m = {1'b0, n, 1'b1} * {2'b0, u};
    a = (m > 5'd16) ? 5'd0 - m : m;
    b = (a > 5'd8) ? 5'd16 - a : a;
    case (b)
      5'd0:    mag = 13'sd2048;
      5'd1:    mag = 13'sd2009;
      5'd2:    mag = 13'sd1892;
      5'd3:    mag = 13'sd1703;
      5'd4:    mag = 13'sd1448;
      5'd5:    mag = 13'sd1138;
      5'd6:    mag = 13'sd784;
      5'd7:    mag = 13'sd400;
      default: mag = 13'sd0;
    endcase
    if (u == 3'd0) return 13'sd1448;
    return (a > 5'd8) ? -mag : mag;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      smp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      (state_q == LOAD): begin
        if (enable) begin
          smp_d = smp_q + 6'd1;
          if (smp_q == 6'd63) begin
            state_d = COMPUTE;
            cnt_d   = '0;
          end
        end
      end
      (state_q == COMPUTE): begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'd128) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // cnt 0..63 row pass, 64..127 column pass, 128 publish
  always_comb begin
    load_en = 1'b0;
    p1_en   = 1'b0;
    p2_en   = 1'b0;
    xfer    = 1'b0;
    unique case (1'b1)
      (state_q == LOAD): load_en = enable;
      (state_q == COMPUTE): begin
        p1_en = ~cnt_q[7] & ~cnt_q[6];
        p2_en = ~cnt_q[7] & cnt_q[6];
        xfer  = cnt_q[7];
      end
    endcase
  end

  always_comb begin
    acc1 = '0;
    acc2 = '0;
    for (int i = 0; i < 8; i++) begin
      acc1 = acc1 + 32'(x_q[{cnt_q[5:3], 3'(i)}])
                  * 32'(coef(cnt_q[2:0], 3'(i)));
      acc2 = acc2 + 48'(t_q[{3'(i), cnt_q[2:0]}])
                  * 48'(coef(cnt_q[5:3], 3'(i)));
    end
    rnd = 24'((acc2 + 48'sd8388608) >>> 24);
    if (rnd > 24'sd1023)
      sat = 11'h3ff;
    else if (rnd < -24'sd1024)
      sat = 11'h400;
    else
      sat = 11'(rnd);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) begin
        x_q[i] <= '0;
        t_q[i] <= '0;
        s_q[i] <= '0;
      end
      Z_final       <= '0;
      output_enable <= 1'b0;
    end else begin
      output_enable <= xfer;
      if (load_en) x_q[smp_q] <= {1'b0, data_in} - 9'd128;
      if (p1_en) t_q[cnt_q[5:0]] <= acc1;
      if (p2_en) s_q[cnt_q[5:0]] <= sat;
      if (xfer) begin
        for (int u = 1; u <= 8; u++)
          for (int v = 1; v <= 8; v++)
            Z_final[u][v] <= s_q[(u - 1) * 8 + (v - 1)];
      end
    end
  end

endmodule

// File: tb/tb_cb_dct_8x8.sv
// Scoreboard bench for cb_dct_8x8: directed blocks, integer and float
// reference DCTs, pulse timing, hold and reset behaviour.
module tb_cb_dct_8x8;

  typedef logic [1:8][1:8][10:0] mat_t;
  typedef struct {
    mat_t z;
    mat_t f;
    int   pcyc;
    int   nh;
    logic [3:0][3:0]  hu;
    logic [3:0][3:0]  hv;
    logic [3:0][10:0] hval;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] data_in = 8'd0;
  mat_t       Z_final;
  logic       output_enable;

  exp_t sb[$];
  exp_t en;
  exp_t e;
  mat_t cur;
  int   blk[64];
  int   cm[8][8];
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;
  int   za, fa;
  real  xr;
  localparam real PI = 3.14159265358979323846;

  cb_dct_8x8 dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .data_in(data_in),
    .Z_final(Z_final),
    .output_enable(output_enable)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      cur = '0;
    end else if (output_enable) begin
      if (sb.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL unexpected_pulse cyc=%0d", cyc);
      end else begin
        e = sb.pop_front();
        nchk++;
        if (cyc != e.pcyc) begin
          nerr++;
          $display("FAIL pulse_time got=%0d exp=%0d", cyc, e.pcyc);
        end
        for (int u = 1; u <= 8; u++)
          for (int v = 1; v <= 8; v++) begin
            nchk++;
            if (Z_final[u][v] !== e.z[u][v]) begin
              nerr++;
              $display("FAIL int_model Z[%0d][%0d] got=%0d exp=%0d", u, v,
                       $signed(Z_final[u][v]), $signed(e.z[u][v]));
            end
            za = $signed(Z_final[u][v]);
            fa = $signed(e.f[u][v]);
            nchk++;
            if (za - fa > 1 || fa - za > 1) begin
              nerr++;
              $display("FAIL float_model Z[%0d][%0d] got=%0d exp=%0d+/-1",
                       u, v, za, fa);
            end
          end
        for (int i = 0; i < e.nh; i++) begin
          nchk++;
          if (Z_final[e.hu[i]][e.hv[i]] !== e.hval[i]) begin
            nerr++;
            $display("FAIL hand Z[%0d][%0d] got=%0d exp=%0d", e.hu[i], e.hv[i],
                     $signed(Z_final[e.hu[i]][e.hv[i]]), $signed(e.hval[i]));
          end
        end
        cur = e.z;
      end
    end else begin
      nchk++;
      if (Z_final !== cur) begin
        nerr++;
        $display("FAIL hold cyc=%0d got=%h exp=%h", cyc, Z_final, cur);
      end
    end
  end

  task automatic fill(input int kind, input int val);
    for (int k = 0; k < 64; k++)
      case (kind)
        0:       blk[k] = k;
        1:       blk[k] = val;
        default: blk[k] = (((k / 8) + (k % 8)) % 2 == 1) ? 255 : 0;
      endcase
  endtask

  task automatic build();
    longint t[64];
    longint a, q;
    real fs, cu, cv;
    for (int r = 0; r < 8; r++)
      for (int v = 0; v < 8; v++) begin
        t[8*r+v] = 0;
        for (int n = 0; n < 8; n++)
          t[8*r+v] += longint'(blk[8*r+n] - 128) * longint'(cm[v][n]);
      end
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++) begin
        a = 0;
        for (int r = 0; r < 8; r++)
          a += longint'(cm[u][r]) * t[8*r+v];
        q = (a + longint'(8388608)) >>> 24;
        if (q > 1023) q = 1023;
        if (q < -1024) q = -1024;
        en.z[u+1][v+1] = 11'(q);
        cu = (u == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        cv = (v == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        fs = 0.0;
        for (int r = 0; r < 8; r++)
          for (int n = 0; n < 8; n++)
            fs += (blk[8*r+n] - 128) * $cos((2*r+1)*u*PI/16.0)
                  * $cos((2*n+1)*v*PI/16.0);
        fs = $floor(fs * cu * cv / 4.0 + 0.5);
        if (fs > 1023.0) fs = 1023.0;
        if (fs < -1024.0) fs = -1024.0;
        en.f[u+1][v+1] = 11'($rtoi(fs));
      end
  endtask

  task automatic hand(input int i, input int u, input int v, input int val);
    en.hu[i] = 4'(u);
    en.hv[i] = 4'(v);
    en.hval[i] = 11'(val);
  endtask

  task automatic load(input int ns, input bit gap);
    for (int k = 0; k < ns; k++) begin
      data_in = 8'(blk[k]);
      enable = 1'b1;
      @(posedge clk); #1;
      enable = 1'b0;
      if (gap && k < ns - 1) begin
        data_in = 8'hA5;
        @(posedge clk); #1;
      end
    end
    enable = 1'b0;
  endtask

  task automatic idle(input int n, input bit busy);
    enable = busy;
    data_in = 8'hFF;
    repeat (n) begin @(posedge clk); #1; end
    enable = 1'b0;
  endtask

  task automatic run(input int kind, input int val, input int dc,
                     input bit gap, input bit busy);
    fill(kind, val);
    build();
    en.hu = '0; en.hv = '0; en.hval = '0;
    case (kind)
      0: begin
        en.nh = 3;
        hand(0, 1, 1, -772); hand(1, 1, 2, -18); hand(2, 2, 1, -146);
      end
      1: begin
        en.nh = 4;
        hand(0, 1, 1, dc); hand(1, 1, 2, 0); hand(2, 2, 1, 0); hand(3, 8, 8, 0);
      end
      default: begin
        en.nh = 2;
        hand(0, 1, 1, -4); hand(1, 8, 8, -838);
      end
    endcase
    load(64, gap);
    en.pcyc = cyc + 129;
    sb.push_back(en);
    idle(129, busy);
  endtask

  task automatic rst_check(input string tag);
    rst = 1'b0;
    #1;
    nchk++;
    if (Z_final !== '0) begin
      nerr++;
      $display("FAIL %s_z got=%h exp=0", tag, Z_final);
    end
    nchk++;
    if (output_enable !== 1'b0) begin
      nerr++;
      $display("FAIL %s_oe got=%b exp=0", tag, output_enable);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    nchk++;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end
  endtask

  initial begin
    for (int u = 0; u < 8; u++)
      for (int n = 0; n < 8; n++) begin
        xr = ((u == 0) ? 4096.0 / (2.0 * $sqrt(2.0)) : 2048.0)
             * $cos((2*n+1)*u*PI/16.0);
        cm[u][n] = (xr >= 0.0) ? $rtoi(xr + 0.5) : -$rtoi(-xr + 0.5);
      end
    repeat (3) @(posedge clk);
    #1;
    nchk++;
    if (Z_final !== '0) begin
      nerr++;
      $display("FAIL reset_z got=%h exp=0", Z_final);
    end
    nchk++;
    if (output_enable !== 1'b0) begin
      nerr++;
      $display("FAIL reset_oe got=%b exp=0", output_enable);
    end
    rst = 1'b1;
    @(posedge clk); #1;

    run(0, 0, 0, 1'b0, 1'b0);
    run(1, 128, 0, 1'b0, 1'b1);
    run(0, 0, 0, 1'b0, 1'b0);
    run(0, 0, 0, 1'b1, 1'b0);
    run(1, 255, 1016, 1'b0, 1'b0);
    run(1, 0, -1024, 1'b0, 1'b0);
    run(2, 0, 0, 1'b0, 1'b0);

    fill(0, 0);
    load(30, 1'b0);
    rst_check("rst_load");
    run(0, 0, 0, 1'b0, 1'b0);

    fill(1, 255);
    load(64, 1'b0);
    idle(60, 1'b1);
    rst_check("rst_compute");
    idle(200, 1'b0);

    run(0, 0, 0, 1'b0, 1'b0);
    drain();
    repeat (4) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
